// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if -- bus bundle between the on-chip requesters, the
// round-robin SRAM arbiter and the external SRAM controller.
//
// Requester side (per requester i, packed by index):
//   req_valid[i], req_we_n[i], req_lock[i]      request, write enable (low), lock
//   req_address[18i+17:18i]                     access address
//   req_write_data[16i+15:16i]                  write data
//   req_grant[i]                                access accepted this cycle
//   rd_valid[i], rd_data                        returning read data for requester i
// SRAM side:
//   SRAM_address, SRAM_write_data, SRAM_we_n    registered access to the controller
//   SRAM_read_data                              read data from the controller
//
// Modports: slave = the arbiter, master = requesters plus SRAM controller.
// ---------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we_n;
  logic [NUM_REQ-1:0]    req_lock;
  logic [NUM_REQ*18-1:0] req_address;
  logic [NUM_REQ*16-1:0] req_write_data;
  logic [NUM_REQ-1:0]    req_grant;
  logic [NUM_REQ-1:0]    rd_valid;
  logic [15:0]           rd_data;
  logic [17:0]           SRAM_address;
  logic [15:0]           SRAM_write_data;
  logic                  SRAM_we_n;
  logic [15:0]           SRAM_read_data;

  modport slave (
    input  req_valid, req_we_n, req_lock, req_address, req_write_data,
    input  SRAM_read_data,
    output req_grant, rd_valid, rd_data,
    output SRAM_address, SRAM_write_data, SRAM_we_n
  );

  modport master (
    output req_valid, req_we_n, req_lock, req_address, req_write_data,
    output SRAM_read_data,
    input  req_grant, rd_valid, rd_data,
    input  SRAM_address, SRAM_write_data, SRAM_we_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter -- shares the single external SRAM port between NUM_REQ
// requesters (BIST, UART loader, VGA fetch) with round-robin arbitration.
//
// One access is accepted per clock. The granted request is registered onto
// SRAM_address / SRAM_write_data / SRAM_we_n on the following edge. Each
// issued read carries a requester tag through a READ_LATENCY+1 stage shift
// register so the returning SRAM_read_data is flagged on rd_valid for the
// requester that issued it. A requester holding req_lock while granted
// becomes owner and is the only one that can be granted until it samples
// its lock low; release takes effect one cycle later.
//
// Ports:
//   Clock   rising-edge system clock
//   Resetn  asynchronous active-low reset
//   bus     sram_arbiter_if.slave (requester handshake + SRAM port)
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int READ_LATENCY = 2
) (
  input  logic          Clock,
  input  logic          Resetn,
  sram_arbiter_if.slave bus
);

  localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = READ_LATENCY + 1;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]     ptr;
  logic               owner_valid;
  logic [IDW-1:0]     owner_id;
  tag_t               tags [DEPTH];

  logic [17:0]        sram_address;
  logic [15:0]        sram_write_data;
  logic               sram_we_n;

  logic               grant_any;
  logic [IDW-1:0]     grant_id;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rd_valid;

  // Grant selection: owner only while locked, otherwise the first valid
  // requester after ptr. The loop runs from the farthest candidate to the
  // nearest so the nearest valid one is the last (winning) assignment.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    grant_any = 1'b0;
    grant_id  = '0;
    grant     = '0;
    if (owner_valid) begin
      if (bus.req_valid[owner_id]) begin
        grant_any = 1'b1;
        grant_id  = owner_id;
      end
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (bus.req_valid[(int'(ptr) + k) % NUM_REQ]) begin
          grant_any = 1'b1;
          grant_id  = IDW'((int'(ptr) + k) % NUM_REQ);
        end
      end
    end
    if (grant_any) grant[grant_id] = 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ptr             <= '0;
      owner_valid     <= 1'b0;
      owner_id        <= '0;
      sram_address    <= '0;
      sram_write_data <= '0;
      sram_we_n       <= 1'b1;
      // NOTE: the tag pipeline is reset, unlike a data RAM; a stale tag
      // surviving reset would raise rd_valid for a read that no longer exists.
      for (int s = 0; s < DEPTH; s++) tags[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here sees the
      // pre-edge values regardless of statement order.
      if (grant_any) begin
        ptr             <= grant_id;
        sram_address    <= bus.req_address[int'(grant_id)*18 +: 18];
        sram_write_data <= bus.req_write_data[int'(grant_id)*16 +: 16];
        sram_we_n       <= bus.req_we_n[grant_id];
      end else begin
        sram_we_n       <= 1'b1;
      end

      // Taking ownership wins over release; an owner granted with its lock
      // low is released by the second branch in the same edge.
      if (grant_any && bus.req_lock[grant_id]) begin
        owner_valid <= 1'b1;
        owner_id    <= grant_id;
      end else if (owner_valid && !bus.req_lock[owner_id]) begin
        owner_valid <= 1'b0;
      end

      tags[0].valid <= grant_any && bus.req_we_n[grant_id];
      tags[0].id    <= grant_id;
      for (int s = 1; s < DEPTH; s++) tags[s] <= tags[s-1];
    end
  end

  // Last stage lines up with SRAM_read_data for the read it tracks.
  always_comb begin
    rd_valid = '0;
    if (tags[DEPTH-1].valid) rd_valid[tags[DEPTH-1].id] = 1'b1;
  end

  assign bus.req_grant       = grant;
  assign bus.rd_valid        = rd_valid;
  assign bus.rd_data         = bus.SRAM_read_data;
  assign bus.SRAM_address    = sram_address;
  assign bus.SRAM_write_data = sram_write_data;
  assign bus.SRAM_we_n       = sram_we_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter -- self-checking bench for sram_arbiter.
// A stand-in SRAM controller with READ_LATENCY cycles of read delay sits on
// the SRAM side. A behavioural model (integer pointer/owner, an associative
// memory and a queue of expected read returns keyed by due cycle) predicts
// every cycle's grant, SRAM outputs and rd_valid/rd_data.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;
  localparam int N  = 3;
  localparam int RL = 2;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clock = ~Clock;

  sram_arbiter_if #(.NUM_REQ(N)) bus ();

  sram_arbiter #(.NUM_REQ(N), .READ_LATENCY(RL)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  // ---------------- SRAM controller stand-in ----------------
  logic [15:0] sram_mem [bit [17:0]];
  logic [15:0] sram_pipe [RL];

  always @(posedge Clock) begin
    if (!bus.SRAM_we_n) sram_mem[bus.SRAM_address] = bus.SRAM_write_data;
    sram_pipe[0] <= sram_mem.exists(bus.SRAM_address) ? sram_mem[bus.SRAM_address] : 16'h0;
    for (int s = 1; s < RL; s++) sram_pipe[s] <= sram_pipe[s-1];
  end
  assign bus.SRAM_read_data = sram_pipe[RL-1];

  // ---------------- requester drive state ----------------
  logic [N-1:0] v_valid, v_we_n, v_lock;
  logic [17:0]  v_addr [N];
  logic [15:0]  v_data [N];
  int           hold [N];

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          id;
    logic [15:0] data;
  } rd_exp_t;

  int          m_ptr;
  int          m_owner;
  logic [17:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_we_n;
  logic [15:0] m_mem [bit [17:0]];
  rd_exp_t     rd_q [$];
  int          cyc;
  int          last_grant;

  // Values sampled from the DUT during the most recent step.
  logic [N-1:0] dut_grant, dut_rdv;
  logic [15:0]  dut_rdata;
  logic [17:0]  dut_addr;
  logic         dut_we_n;

  int total = 0;
  int bad   = 0;

  function automatic int model_pick();
    if (m_owner >= 0) return v_valid[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++)
      if (v_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr      = 0;
    m_owner    = -1;
    m_addr     = '0;
    m_wdata    = '0;
    m_we_n     = 1'b1;
    last_grant = -1;
    rd_q.delete();
  endtask

  task automatic drive();
    bus.req_valid = v_valid;
    bus.req_we_n  = v_we_n;
    bus.req_lock  = v_lock;
    for (int i = 0; i < N; i++) begin
      bus.req_address[18*i +: 18]    = v_addr[i];
      bus.req_write_data[16*i +: 16] = v_data[i];
    end
  endtask

  task automatic set_req(input int i, input logic we_n, input logic [17:0] a,
                         input logic [15:0] d, input logic lk);
    v_valid[i] = 1'b1;
    v_we_n[i]  = we_n;
    v_addr[i]  = a;
    v_data[i]  = d;
    v_lock[i]  = lk;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the
  // model across the edge. Entered and left 1 time unit after a rising edge.
  task automatic step();
    int           g;
    logic [N-1:0] exp_grant, exp_rd;
    logic [15:0]  exp_rdata;
    drive();
    #1;
    g = model_pick();
    exp_grant = '0;
    if (g >= 0) exp_grant[g] = 1'b1;
    dut_grant = bus.req_grant;
    dut_rdv   = bus.rd_valid;
    dut_rdata = bus.rd_data;
    dut_addr  = bus.SRAM_address;
    dut_we_n  = bus.SRAM_we_n;

    total++;
    if (dut_grant !== exp_grant) begin
      bad++;
      $display("FAIL grant cyc=%0d: got %b want %b", cyc, dut_grant, exp_grant);
    end

    exp_rd    = '0;
    exp_rdata = '0;
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      exp_rd[rd_q[0].id] = 1'b1;
      exp_rdata = rd_q[0].data;
      void'(rd_q.pop_front());
    end
    total++;
    if (dut_rdv !== exp_rd) begin
      bad++;
      $display("FAIL rd_valid cyc=%0d: got %b want %b", cyc, dut_rdv, exp_rd);
    end
    if (exp_rd != '0) begin
      total++;
      if (dut_rdata !== exp_rdata) begin
        bad++;
        $display("FAIL rd_data cyc=%0d: got %h want %h", cyc, dut_rdata, exp_rdata);
      end
    end

    total++;
    if ({bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data} !== {m_we_n, m_addr, m_wdata}) begin
      bad++;
      $display("FAIL sram_out cyc=%0d: got we_n=%b a=%h d=%h want we_n=%b a=%h d=%h",
               cyc, bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data, m_we_n, m_addr, m_wdata);
    end

    if (g >= 0) begin
      m_ptr   = g;
      m_addr  = v_addr[g];
      m_wdata = v_data[g];
      m_we_n  = v_we_n[g];
      if (!v_we_n[g]) m_mem[v_addr[g]] = v_data[g];
      else rd_q.push_back('{due: cyc + 1 + RL, id: g,
                            data: m_mem.exists(v_addr[g]) ? m_mem[v_addr[g]] : 16'h0});
    end else begin
      m_we_n = 1'b1;
    end
    if (g >= 0 && v_lock[g]) m_owner = g;
    else if (m_owner >= 0 && !v_lock[m_owner]) m_owner = -1;
    last_grant = g;
    if (g >= 0) v_valid[g] = 1'b0;

    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    v_valid = '0;
    v_lock  = '0;
    v_we_n  = '1;
    drive();
    Resetn = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    model_reset();
  endtask

  task automatic idle_drain(input int n);
    v_valid = '0;
    v_lock  = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    drive();
    #1;
    total++;
    if ({bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data, bus.rd_valid, bus.req_grant}
        !== {1'b1, 18'h0, 16'h0, 3'b000, 3'b000}) begin
      bad++;
      $display("FAIL reset_values: got we_n=%b a=%h d=%h rdv=%b gnt=%b want 1/0/0/000/000",
               bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data, bus.rd_valid, bus.req_grant);
    end
    @(posedge Clock);
    #1;
    idle_drain(2);
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b0, 18'h00005, 16'h1234, 1'b0);
    step();
    total++;
    if ({bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data} !== {1'b0, 18'h00005, 16'h1234}) begin
      bad++;
      $display("FAIL single_write_issue: got we_n=%b a=%h d=%h want 0/00005/1234",
               bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data);
    end
    set_req(0, 1'b1, 18'h00005, 16'h0000, 1'b0);
    step();
    step();
    step();
    #1;
    total++;
    if ({bus.rd_valid, bus.rd_data} !== {3'b001, 16'h1234}) begin
      bad++;
      $display("FAIL single_read_return: got rdv=%b data=%h want 001/1234", bus.rd_valid, bus.rd_data);
    end
    idle_drain(3);
  endtask

  task automatic test_round_robin();
    int exp_seq [6] = '{1, 2, 0, 1, 2, 0};
    int cnt [N];
    logic [N-1:0] want;
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++)
        if (!v_valid[i]) set_req(i, 1'($urandom_range(0, 1)), 18'($urandom_range(0, 63)),
                                 16'($urandom), 1'b0);
      step();
      want = '0;
      want[exp_seq[k]] = 1'b1;
      total++;
      if (dut_grant !== want) begin
        bad++;
        $display("FAIL rr_order step=%0d: got %b want %b", k, dut_grant, want);
      end
      for (int i = 0; i < N; i++) if (dut_grant[i]) cnt[i]++;
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (cnt[i] != 2) begin
        bad++;
        $display("FAIL rr_fair req=%0d: got %0d grants want 2", i, cnt[i]);
      end
    end
    idle_drain(4);
  endtask

  task automatic test_lock();
    do_reset();
    set_req(0, 1'b0, 18'h00010, 16'($urandom), 1'b1);
    step();
    total++;
    if (dut_grant !== 3'b001) begin
      bad++;
      $display("FAIL lock_take: got %b want 001", dut_grant);
    end
    set_req(1, 1'b1, 18'h00010, 16'h0, 1'b0);
    set_req(2, 1'b1, 18'h00011, 16'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'($urandom_range(0, 1)), 18'(16 + k), 16'($urandom), 1'b1);
      step();
      total++;
      if (dut_grant !== 3'b001) begin
        bad++;
        $display("FAIL lock_hold access=%0d: got %b want 001", k, dut_grant);
      end
    end
    // Owner idles with the lock held, then drops the lock; that cycle still
    // belongs to the owner, so the others get in only on the cycle after.
    for (int k = 0; k < 3; k++) begin
      v_valid[0] = 1'b0;
      v_lock[0]  = (k < 2);
      step();
      total++;
      if (dut_grant !== 3'b000) begin
        bad++;
        $display("FAIL lock_stall cyc=%0d: got %b want 000", k, dut_grant);
      end
    end
    step();
    total++;
    if (dut_grant !== 3'b010) begin
      bad++;
      $display("FAIL lock_release_next: got %b want 010", dut_grant);
    end
    step();
    idle_drain(4);
  endtask

  task automatic test_interleaved();
    logic [N-1:0] rdv [8];
    logic [15:0]  rdd [8];
    int           p;
    do_reset();
    set_req(0, 1'b0, 18'h00100, 16'hAAAA, 1'b0);
    step();
    set_req(0, 1'b0, 18'h00200, 16'h5555, 1'b0);
    step();
    set_req(1, 1'b1, 18'h00100, 16'h0, 1'b0);
    set_req(2, 1'b1, 18'h00200, 16'h0, 1'b0);
    p = -1;
    for (int k = 0; k < 8; k++) begin
      step();
      rdv[k] = dut_rdv;
      rdd[k] = dut_rdata;
      if (p < 0 && dut_rdv == 3'b010) p = k;
    end
    total++;
    if (p < 0 || p > 6) begin
      bad++;
      $display("FAIL interleave_first: got no 010 pulse want rd_valid=010 with data aaaa");
    end else begin
      if (rdd[p] !== 16'hAAAA) begin
        bad++;
        $display("FAIL interleave_first: got data %h want aaaa", rdd[p]);
      end
      total++;
      if ({rdv[p+1], rdd[p+1]} !== {3'b100, 16'h5555}) begin
        bad++;
        $display("FAIL interleave_second: got rdv=%b data=%h want 100/5555", rdv[p+1], rdd[p+1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    set_req(1, 1'b1, 18'h00100, 16'h0, 1'b0);
    step();
    v_valid = '0;
    drive();
    Resetn = 1'b0;
    #1;
    total++;
    if ({bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data, bus.rd_valid, bus.req_grant}
        !== {1'b1, 18'h0, 16'h0, 3'b000, 3'b000}) begin
      bad++;
      $display("FAIL midreset_values: got we_n=%b a=%h d=%h rdv=%b gnt=%b want 1/0/0/000/000",
               bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data, bus.rd_valid, bus.req_grant);
    end
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    model_reset();
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (dut_rdv != '0 || dut_we_n !== 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midreset_quiet: got %0d cycles with rd_valid or write want 0", seen);
    end
  endtask

  task automatic test_idle();
    int errs;
    do_reset();
    set_req(2, 1'b0, 18'h2ABCD, 16'($urandom), 1'b0);
    step();
    step();
    errs = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (dut_grant != '0 || dut_we_n !== 1'b1 || dut_addr !== 18'h2ABCD || dut_rdv != '0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL idle_hold: got %0d bad idle cycles want 0", errs);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (v_lock[i] && !v_valid[i]) begin
          if (m_owner == i && hold[i] > 0) hold[i]--;
          else v_lock[i] = 1'b0;
        end
        if (!v_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, 1'($urandom_range(0, 1)), 18'($urandom_range(0, 15)), 16'($urandom), v_lock[i]);
          if (!v_lock[i]) begin
            v_lock[i] = ($urandom_range(0, 7) == 0);
            hold[i]   = $urandom_range(0, 3);
          end
        end
      end
      step();
    end
    idle_drain(8);
  endtask

  initial begin
    v_valid = '0;
    v_we_n  = '1;
    v_lock  = '0;
    for (int i = 0; i < N; i++) begin
      v_addr[i] = '0;
      v_data[i] = '0;
    end
    cyc = 0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_interleaved();
    test_reset_mid();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
